// File: rtl/arbiter_pkg.sv
// Shared types and helpers for the L1-to-L2 memory arbiter (mem_arbiter_n)
// and its rotating-priority picker.
package arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } arb_op_t;

  // Width of a client index; never below one bit so a 1-bit bus always exists.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/arb_rr_picker.sv
// Rotating priority encoder: searches the request vector starting one past
// base_i, wrapping modulo NUM_CLIENTS (non-power-of-two counts supported).
// With base_i tied to NUM_CLIENTS-1 the search always starts at client 0,
// which is exactly a fixed lowest-index-wins encoder.
module arb_rr_picker
  import arbiter_pkg::*;
#(
  parameter int NUM_CLIENTS = 2,
  parameter int IW          = idx_width(NUM_CLIENTS)
) (
  input  logic [NUM_CLIENTS-1:0] req_i,
  input  logic [IW-1:0]          base_i,
  output logic                   valid_o,
  output logic [IW-1:0]          idx_o
);

  int cand;

  // First requester found walking from base_i+1 around the ring wins.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    valid_o = 1'b0;
    idx_o   = '0;
    cand    = 0;
    for (int i = 1; i <= NUM_CLIENTS; i++) begin
      cand = int'(base_i) + i;
      if (cand >= NUM_CLIENTS) cand = cand - NUM_CLIENTS;
      if (!valid_o && req_i[cand]) begin
        valid_o = 1'b1;
        idx_o   = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter_n.sv
// N-client registered arbiter in front of the single L2/memory port.
// Client 0 is the I$, client 1 the D$. The winner's op, address and write
// line are latched at grant and held on mem_* until mem_resp; the response
// pulse goes to that client only, followed by one mandatory RELEASE cycle in
// which the client drops its request.
// Build option: define ARB_ROUND_ROBIN_EN for round-robin arbitration (last
// winner becomes lowest priority); otherwise fixed priority, lowest index wins.
module mem_arbiter_n
  import arbiter_pkg::*;
#(
  parameter int NUM_CLIENTS = 2,
  parameter int CWIDTH      = 256,
  parameter int AWIDTH      = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CLIENTS-1:0]        c_read,
  input  logic [NUM_CLIENTS-1:0]        c_write,
  input  logic [NUM_CLIENTS*AWIDTH-1:0] c_addr,
  input  logic [NUM_CLIENTS*CWIDTH-1:0] c_wdata,
  output logic [CWIDTH-1:0]             c_rdata,
  output logic [NUM_CLIENTS-1:0]        c_resp,
  output logic                          mem_read,
  output logic                          mem_write,
  output logic [AWIDTH-1:0]             mem_addr,
  output logic [CWIDTH-1:0]             mem_wdata,
  input  logic [CWIDTH-1:0]             mem_rdata,
  input  logic                          mem_resp,
  output logic                          busy,
  output logic [$clog2(NUM_CLIENTS)-1:0] grant_idx
);

  localparam int IW = idx_width(NUM_CLIENTS);

  localparam logic [1:0] ST_IDLE    = IDLE;
  localparam logic [1:0] ST_BUSY    = BUSY;
  localparam logic [1:0] ST_RELEASE = RELEASE;

  logic [1:0]             state_q, state_d;
  logic                   mem_read_q, mem_read_d;
  logic                   mem_write_q, mem_write_d;
  logic [AWIDTH-1:0]      addr_q, addr_d;
  logic [CWIDTH-1:0]      wdata_q, wdata_d;
  logic [IW-1:0]          grant_q, grant_d;

  logic [NUM_CLIENTS-1:0] req;
  logic [IW-1:0]          ptr;
  logic                   pick_valid;
  logic [IW-1:0]          pick_idx;
  arb_op_t                pick_op;

  // A client asking for both read and write is treated as a write.
  assign req     = c_read | c_write;
  assign pick_op = c_write[pick_idx] ? OP_WRITE : OP_READ;

`ifdef ARB_ROUND_ROBIN_EN
  logic [IW-1:0] ptr_q, ptr_d;

  // The pointer moves to the last winner during RELEASE, making it lowest priority.
  always_comb begin
    ptr_d = (state_q == ST_RELEASE) ? grant_q : ptr_q;
  end

  // Pointer register; resets to the last client so client 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= IW'(NUM_CLIENTS - 1);
    else     ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;
`else
  assign ptr = IW'(NUM_CLIENTS - 1);
`endif

  arb_rr_picker #(
    .NUM_CLIENTS (NUM_CLIENTS),
    .IW          (IW)
  ) u_picker (
    .req_i   (req),
    .base_i  (ptr),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  // FSM next state: grant and latch in IDLE, wait for mem_resp in BUSY,
  // one dead cycle in RELEASE.
  always_comb begin
    state_d     = state_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    grant_d     = grant_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_d     = pick_idx;
          addr_d      = c_addr[int'(pick_idx)*AWIDTH +: AWIDTH];
          wdata_d     = c_wdata[int'(pick_idx)*CWIDTH +: CWIDTH];
          mem_write_d = (pick_op == OP_WRITE);
          mem_read_d  = (pick_op == OP_READ);
          state_d     = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (mem_resp) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          state_d     = ST_RELEASE;
        end
      end
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // State and latch registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: the wide address/data latches are reset as well, so mem_addr and
    // mem_wdata read as zero after reset instead of carrying stale lines.
    if (rst) begin
      state_q     <= ST_IDLE;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      grant_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from the
      // same pre-edge values, independent of statement order.
      state_q     <= state_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      grant_q     <= grant_d;
    end
  end

  // Response pulse goes combinationally to the latched winner only.
  always_comb begin
    c_resp = '0;
    if (state_q == ST_BUSY && mem_resp) c_resp[grant_q] = 1'b1;
  end

  assign c_rdata   = mem_rdata;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != ST_IDLE);
  assign grant_idx = grant_q;

  // Protocol checks: no client drives read and write together, and L2 only
  // responds while a transaction is outstanding.
  a_no_read_and_write: assert property (@(posedge clk) disable iff (rst)
    (c_read & c_write) == '0);
  a_resp_only_in_busy: assert property (@(posedge clk) disable iff (rst)
    mem_resp |-> (state_q == ST_BUSY));

endmodule

// File: tb/tb_mem_arbiter_n.sv
// Scoreboard bench for mem_arbiter_n with three clients (non-power-of-two).
// A transaction-level model predicts the winner from the requests the bench
// itself drives; a separate monitor checks mem_*, busy and c_resp.
module tb_mem_arbiter_n;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int CW = 64;
  localparam int IW = 2;

  typedef struct {
    int             due;
    int             idx;
    bit             wr;
    logic [AW-1:0]  addr;
    logic [CW-1:0]  wdata;
  } grant_t;

  typedef struct {
    int             due;
    logic [N-1:0]   onehot;
    logic [CW-1:0]  rdata;
  } resp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    c_read, c_write, c_resp;
  logic [N*AW-1:0] c_addr;
  logic [N*CW-1:0] c_wdata;
  logic [CW-1:0]   c_rdata, mem_wdata, mem_rdata;
  logic            mem_read, mem_write, mem_resp, busy;
  logic [AW-1:0]   mem_addr;
  logic [IW-1:0]   grant_idx;

  mem_arbiter_n #(.NUM_CLIENTS(N), .CWIDTH(CW), .AWIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .c_read(c_read), .c_write(c_write), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_rdata(c_rdata), .c_resp(c_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .busy(busy), .grant_idx(grant_idx)
  );

  always #5 clk = ~clk;

  grant_t exp_grant[$];
  resp_t  exp_resp[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Model state
  logic [N-1:0] pend;
  int  drop_at[N];
  int  free_cycle, grant_cycle, resp_cycle, win, last;
  bit  inflight;
  int  raise_pct, fixed_lat;
  bit  scramble_en, zero_scr;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [CW-1:0] rand_line();
    return {$urandom, $urandom};
  endfunction

  // Arbitration rule: round-robin from the client after the last winner, or
  // lowest index first.
  function automatic int pick(input logic [N-1:0] r, input int lst);
`ifdef ARB_ROUND_ROBIN_EN
    for (int k = 1; k <= N; k++) if (r[(lst + k) % N]) return (lst + k) % N;
`else
    for (int k = 0; k < N; k++) if (r[k]) return k + 0 * lst;
`endif
    return -1;
  endfunction

  task automatic raise(input int i, input bit wr, input logic [AW-1:0] a, input logic [CW-1:0] d);
    pend[i]    = 1'b1;
    c_read[i]  = !wr;
    c_write[i] = wr;
    c_addr[i*AW +: AW]  = a;
    c_wdata[i*CW +: CW] = d;
    drop_at[i] = -1;
  endtask

  task automatic drop(input int i);
    pend[i]    = 1'b0;
    c_read[i]  = 1'b0;
    c_write[i] = 1'b0;
    drop_at[i] = -1;
  endtask

  // Start of a cycle: L2 responder, request drops/raises, in-flight scrambling.
  task automatic cycle_begin();
    logic [CW-1:0] rd;
    logic [N-1:0]  oh;
    @(posedge clk); #1;
    cyc++;
    mem_resp  = 1'b0;
    mem_rdata = rand_line();
    if (!rst && inflight && cyc == resp_cycle) begin
      rd = rand_line();
      oh = '0;
      oh[win] = 1'b1;
      mem_resp  = 1'b1;
      mem_rdata = rd;
      exp_resp.push_back('{due: cyc, onehot: oh, rdata: rd});
      drop_at[win] = cyc + 2;   // client keeps requesting through RELEASE
      free_cycle   = cyc + 2;
      inflight     = 1'b0;
    end
    for (int i = 0; i < N; i++)
      if (pend[i] && drop_at[i] == cyc) drop(i);
    for (int i = 0; i < N; i++)
      if (!pend[i] && $urandom_range(99) < raise_pct)
        raise(i, 1'($urandom_range(1)), $urandom, rand_line());
    if (scramble_en && inflight && cyc > grant_cycle) begin
      c_addr[win*AW +: AW]  = zero_scr ? '0 : $urandom;
      c_wdata[win*CW +: CW] = zero_scr ? '0 : rand_line();
    end
  endtask

  // End of a cycle: if the arbiter is free, predict the grant it must make.
  task automatic cycle_end();
    int w;
    if (!rst && !inflight && cyc >= free_cycle && pend != '0) begin
      w = pick(pend, last);
      exp_grant.push_back('{due: cyc + 1, idx: w, wr: c_write[w],
                            addr: c_addr[w*AW +: AW], wdata: c_wdata[w*CW +: CW]});
      inflight    = 1'b1;
      win         = w;
      grant_cycle = cyc;
      resp_cycle  = cyc + 1 + ((fixed_lat >= 0) ? fixed_lat : int'($urandom_range(3)));
      last        = w;
    end
  endtask

  task automatic tick();
    cycle_begin();
    cycle_end();
  endtask

  task automatic do_reset(input int n);
    @(posedge clk); #1;
    cyc++;
    rst = 1'b1;
    mem_resp = 1'b0;
    exp_grant.delete();
    exp_resp.delete();
    inflight = 1'b0;
    last = N - 1;
    for (int i = 0; i < N; i++) drop_at[i] = -1;
    repeat (n - 1) begin @(posedge clk); #1; cyc++; end
    @(posedge clk); #1;
    cyc++;
    rst = 1'b0;
    free_cycle = cyc;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(pend == '0 && !inflight && cyc >= free_cycle) && n < 500) begin
      tick();
      n++;
    end
    check("drain_bound", n < 500, 1);
  endtask

  // Monitor: compares DUT outputs against the scoreboard mid-cycle.
  initial begin : monitor
    bit active = 1'b0;
    bit resp_last = 1'b0;
    bit rst_prev = 1'b1;
    bit rel;
    grant_t cur, g;
    resp_t  r;
    forever begin
      @(negedge clk);
      if (rst_prev) begin
        check("rst_mem_read", mem_read, 0);
        check("rst_mem_write", mem_write, 0);
        check("rst_busy", busy, 0);
        check("rst_c_resp", c_resp, 0);
        check("rst_grant_idx", grant_idx, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        active = 1'b0;
        resp_last = 1'b0;
      end else begin
        rel = resp_last;
        resp_last = 1'b0;
        if (exp_grant.size() != 0 && exp_grant[0].due == cyc) begin
          g = exp_grant.pop_front();
          active = 1'b1;
          cur = g;
        end else if ((mem_read || mem_write) && !active) begin
          check("unexpected_grant", {mem_read, mem_write}, 0);
        end
        if (active) begin
          check("hold_op", {mem_read, mem_write}, cur.wr ? 2'b01 : 2'b10);
          check("hold_idx", grant_idx, cur.idx);
          check("hold_addr", mem_addr, cur.addr);
          check("hold_wdata", mem_wdata, cur.wdata);
        end
        check("busy", busy, active || rel);
        if (exp_resp.size() != 0 && exp_resp[0].due == cyc) begin
          r = exp_resp.pop_front();
          check("c_resp", c_resp, r.onehot);
          check("c_rdata", c_rdata, r.rdata);
          active = 1'b0;
          resp_last = 1'b1;
        end else begin
          check("c_resp_quiet", c_resp, 0);
        end
      end
      rst_prev = rst;
    end
  end

  // Stimulus
  initial begin
    c_read = '0; c_write = '0; c_addr = '0; c_wdata = '0;
    mem_resp = 1'b0; mem_rdata = '0;
    pend = '0;
    for (int i = 0; i < N; i++) drop_at[i] = -1;
    free_cycle = 0; grant_cycle = 0; resp_cycle = 0; win = 0; last = N - 1;
    inflight = 1'b0; raise_pct = 0; fixed_lat = -1;
    scramble_en = 1'b0; zero_scr = 1'b0;

    do_reset(2);
    cycle_end();

    // Single read from the D$.
    fixed_lat = 4;
    cycle_begin();
    raise(1, 1'b0, 32'h0000_1040, rand_line());
    cycle_end();
    wait_idle();

    // Write whose address/data change to zero while it is outstanding.
    fixed_lat = 3; scramble_en = 1'b1; zero_scr = 1'b1;
    cycle_begin();
    raise(1, 1'b1, 32'h8000_0000, '1);
    cycle_end();
    wait_idle();
    scramble_en = 1'b0; zero_scr = 1'b0; fixed_lat = -1;

    // Continuous contention from every client.
    raise_pct = 100;
    repeat (80) tick();
    raise_pct = 0;
    wait_idle();

    // Random traffic with mid-transaction address/data churn.
    raise_pct = 35; scramble_en = 1'b1;
    repeat (3000) tick();
    raise_pct = 0; scramble_en = 1'b0;
    wait_idle();

    // Reset while a read is outstanding; first grant after reset goes to client 0.
    fixed_lat = 6;
    cycle_begin();
    raise(2, 1'b0, $urandom, rand_line());
    cycle_end();
    for (int k = 0; k < 20 && !(inflight && cyc >= grant_cycle + 2); k++) tick();
    do_reset(2);
    if (!pend[0]) raise(0, 1'b0, $urandom, rand_line());
    if (!pend[1]) raise(1, 1'b1, $urandom, rand_line());
    cycle_end();
    check("post_reset_winner", win, 0);
    fixed_lat = -1;
    wait_idle();

    repeat (5) tick();
    check("grant_queue_empty", exp_grant.size(), 0);
    check("resp_queue_empty", exp_resp.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
